// File: rtl/alu_pkg.sv
// Shared definitions for the parameterised ALU: op codes, control states and
// the bit positions of the status flags.
package alu_pkg;

    // Operation select encodings
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_SHL  = 4'h3;
    localparam logic [3:0] OP_SHR  = 4'h4;
    localparam logic [3:0] OP_INCA = 4'h5;
    localparam logic [3:0] OP_INCB = 4'h6;
    localparam logic [3:0] OP_DECA = 4'h7;
    localparam logic [3:0] OP_DECB = 4'h8;
    localparam logic [3:0] OP_EQ   = 4'h9;
    localparam logic [3:0] OP_GT   = 4'hA;
    localparam logic [3:0] OP_LT   = 4'hB;
    localparam logic [3:0] OP_NOTA = 4'hC;
    localparam logic [3:0] OP_NOTB = 4'hD;
    localparam logic [3:0] OP_AND  = 4'hE;
    localparam logic [3:0] OP_OR   = 4'hF;

    // Control states of the ALU sequencer
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Bit positions inside the 4-bit flag vector {V,N,C,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // Places the individual flag bits at their fixed positions
    function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                              input logic c, input logic z);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier. The product register starts as {0, B}; each
// iteration conditionally adds A into the upper half and shifts right by one,
// so after ITERS iterations it holds the full 2*WIDTH-bit product. The first
// iteration is folded into the start cycle so the result is ready ITERS cycles
// after start, with a one-cycle done pulse alongside the last iteration.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ITERS = WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);

    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;

    // One shift-add step: add multiplicand into the high half when the
    // current multiplier bit (LSB) is set, then shift everything right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
        return {sum, p[WIDTH-1:1]};
    endfunction

    // Iteration engine: load on start, step while busy, pulse done on the last step
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prod_r  <= {(2*WIDTH){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (start) begin
            prod_r  <= mul_step({{WIDTH{1'b0}}, op_b}, op_a);
            mcand_r <= op_a;
            cnt_r   <= CNT_LOAD;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else if (busy_r) begin
            prod_r <= mul_step(prod_r, mcand_r);
            cnt_r  <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = prod_r;

endmodule

// File: rtl/param_alu.sv
// Parameterised ALU with valid/ready handshakes on both sides. Single-cycle
// ops complete in one cycle; multiply runs through the sequential shift-add
// unit. Results and flags are held in DONE until the consumer takes them.
module param_alu
    import alu_pkg::*;
#(
    parameter int WIDTH              = 8,
    parameter int MUL_CYCLES_PER_BIT = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    input  logic [3:0]       ALU_Op_Code,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_RESULT,
    output logic [WIDTH-1:0] OUT_RESULT_HI,
    output logic [3:0]       OUT_FLAGS
);

    localparam int MUL_ITERS = WIDTH * MUL_CYCLES_PER_BIT;
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    alu_state_e state_r;
    alu_state_e state_nxt_s;

    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_hi_r;
    logic [3:0]       flags_r;

    logic [WIDTH-1:0] lhs_s;
    logic [WIDTH-1:0] rhs_s;
    logic             sub_s;
    logic [WIDTH-1:0] rhs_eff_s;
    logic [WIDTH:0]   sum_s;
    logic             ovf_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;

    logic               accept_s;
    logic               alu_load_s;
    logic               mul_start_s;
    logic               mul_load_s;
    logic               handoff_s;
    logic               mul_busy_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;

    assign accept_s    = (state_r == IDLE) && IN_VALID;
    assign mul_start_s = accept_s && (ALU_Op_Code == OP_MUL);
    assign alu_load_s  = accept_s && (ALU_Op_Code != OP_MUL);
    assign mul_load_s  = (state_r == MUL) && mul_done_s;
    assign handoff_s   = (state_r == DONE) && out_valid_r && OUT_READY;

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .ITERS (MUL_ITERS)
    ) u_mul (
        .CLK     (CLK),
        .RESET   (RESET),
        .start   (mul_start_s),
        .op_a    (IN_A),
        .op_b    (IN_B),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Operand routing for the shared adder/subtractor used by the arithmetic ops
    always_comb begin
        lhs_s = IN_A;
        rhs_s = IN_B;
        sub_s = 1'b0;
        case (ALU_Op_Code)
            OP_ADD:  begin lhs_s = IN_A; rhs_s = IN_B;  sub_s = 1'b0; end
            OP_SUB:  begin lhs_s = IN_A; rhs_s = IN_B;  sub_s = 1'b1; end
            OP_INCA: begin lhs_s = IN_A; rhs_s = ONE_W; sub_s = 1'b0; end
            OP_INCB: begin lhs_s = IN_B; rhs_s = ONE_W; sub_s = 1'b0; end
            OP_DECA: begin lhs_s = IN_A; rhs_s = ONE_W; sub_s = 1'b1; end
            OP_DECB: begin lhs_s = IN_B; rhs_s = ONE_W; sub_s = 1'b1; end
            default: begin lhs_s = IN_A; rhs_s = IN_B;  sub_s = 1'b0; end
        endcase
    end

    // Shared adder: bit WIDTH is carry for add and borrow for subtract
    always_comb begin
        rhs_eff_s = sub_s ? ~rhs_s : rhs_s;
        if (sub_s) begin
            sum_s = {1'b0, lhs_s} - {1'b0, rhs_s};
        end else begin
            sum_s = {1'b0, lhs_s} + {1'b0, rhs_s};
        end
        ovf_s = (lhs_s[WIDTH-1] == rhs_eff_s[WIDTH-1]) &&
                (sum_s[WIDTH-1] != lhs_s[WIDTH-1]);
    end

    // Single-cycle result, carry and overflow selection for every non-multiply op
    always_comb begin
        alu_res_s = ZERO_W;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (ALU_Op_Code)
            OP_ADD, OP_SUB, OP_INCA, OP_INCB, OP_DECA, OP_DECB: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = ovf_s;
            end
            OP_SHL: begin
                alu_res_s = {IN_A[WIDTH-2:0], 1'b0};
                alu_c_s   = IN_A[WIDTH-1];
            end
            OP_SHR: begin
                alu_res_s = {1'b0, IN_A[WIDTH-1:1]};
                alu_c_s   = IN_A[0];
            end
            OP_EQ:   alu_res_s = {{(WIDTH-1){1'b0}}, (IN_A == IN_B)};
            OP_GT:   alu_res_s = {{(WIDTH-1){1'b0}}, (IN_A >  IN_B)};
            OP_LT:   alu_res_s = {{(WIDTH-1){1'b0}}, (IN_A <  IN_B)};
            OP_NOTA: alu_res_s = ~IN_A;
            OP_NOTB: alu_res_s = ~IN_B;
            OP_AND:  alu_res_s = IN_A & IN_B;
            OP_OR:   alu_res_s = IN_A | IN_B;
            default: alu_res_s = ZERO_W;
        endcase
    end

    // Next-state logic; a MUL state whose multiplier is neither busy nor done
    // falls back to IDLE rather than hanging
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (IN_VALID) begin
                    state_nxt_s = (ALU_Op_Code == OP_MUL) ? MUL : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    state_nxt_s = DONE;
                end else if (!mul_busy_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = MUL;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered outputs: load on completion, clear valid on handoff, hold otherwise
    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= ZERO_W;
            result_hi_r <= ZERO_W;
            flags_r     <= 4'b0000;
        end else begin
            in_ready_r <= (state_nxt_s == IDLE);
            if (alu_load_s) begin
                out_valid_r <= 1'b1;
                result_r    <= alu_res_s;
                result_hi_r <= ZERO_W;
                flags_r     <= pack_flags(alu_v_s, alu_res_s[WIDTH-1], alu_c_s,
                                          (alu_res_s == ZERO_W));
            end else if (mul_load_s) begin
                out_valid_r <= 1'b1;
                result_r    <= mul_prod_s[WIDTH-1:0];
                result_hi_r <= mul_prod_s[2*WIDTH-1:WIDTH];
                flags_r     <= pack_flags(1'b0, mul_prod_s[WIDTH-1],
                                          (mul_prod_s[2*WIDTH-1:WIDTH] != ZERO_W),
                                          (mul_prod_s[WIDTH-1:0] == ZERO_W));
            end else if (handoff_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign IN_READY      = in_ready_r;
    assign OUT_VALID     = out_valid_r;
    assign OUT_RESULT    = result_r;
    assign OUT_RESULT_HI = result_hi_r;
    assign OUT_FLAGS     = flags_r;

endmodule

// File: tb/tb_param_alu.sv
// Directed testbench for param_alu: an 8-bit instance covers the handshake,
// every op code, multiply latency, back-pressure and reset; a 16-bit instance
// covers the width-dependent shift case.
module tb_param_alu;

    logic        clk;
    logic        RESET;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  op_code;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_result;
    logic [7:0]  out_result_hi;
    logic [3:0]  out_flags;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [15:0] w_in_a;
    logic [15:0] w_in_b;
    logic [3:0]  w_op_code;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [15:0] w_out_result;
    logic [15:0] w_out_result_hi;
    logic [3:0]  w_out_flags;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // {op, a, b, expected result, expected flags {V,N,C,Z}}
    localparam logic [31:0] VECS [0:16] = '{
        {4'h0, 8'hFF, 8'h01, 8'h00, 4'b0011},
        {4'h1, 8'h80, 8'h01, 8'h7F, 4'b1000},
        {4'h1, 8'h01, 8'h02, 8'hFF, 4'b0110},
        {4'h0, 8'h7F, 8'h01, 8'h80, 4'b1100},
        {4'h3, 8'h81, 8'h00, 8'h02, 4'b0010},
        {4'h4, 8'h81, 8'h00, 8'h40, 4'b0010},
        {4'h5, 8'hFF, 8'h00, 8'h00, 4'b0011},
        {4'h6, 8'h00, 8'h7F, 8'h80, 4'b1100},
        {4'h7, 8'h00, 8'h00, 8'hFF, 4'b0110},
        {4'h8, 8'h00, 8'h80, 8'h7F, 4'b1000},
        {4'h9, 8'h5A, 8'h5A, 8'h01, 4'b0000},
        {4'hA, 8'h80, 8'h7F, 8'h01, 4'b0000},
        {4'hB, 8'h80, 8'h7F, 8'h00, 4'b0001},
        {4'hC, 8'h0F, 8'h00, 8'hF0, 4'b0100},
        {4'hD, 8'h00, 8'hFF, 8'h00, 4'b0001},
        {4'hE, 8'hF0, 8'h3C, 8'h30, 4'b0000},
        {4'hF, 8'h80, 8'h01, 8'h81, 4'b0100}
    };

    param_alu #(.WIDTH(8), .MUL_CYCLES_PER_BIT(1)) dut8 (
        .CLK           (clk),
        .RESET         (RESET),
        .IN_VALID      (in_valid),
        .IN_READY      (in_ready),
        .IN_A          (in_a),
        .IN_B          (in_b),
        .ALU_Op_Code   (op_code),
        .OUT_VALID     (out_valid),
        .OUT_READY     (out_ready),
        .OUT_RESULT    (out_result),
        .OUT_RESULT_HI (out_result_hi),
        .OUT_FLAGS     (out_flags)
    );

    param_alu #(.WIDTH(16), .MUL_CYCLES_PER_BIT(1)) dut16 (
        .CLK           (clk),
        .RESET         (RESET),
        .IN_VALID      (w_in_valid),
        .IN_READY      (w_in_ready),
        .IN_A          (w_in_a),
        .IN_B          (w_in_b),
        .ALU_Op_Code   (w_op_code),
        .OUT_VALID     (w_out_valid),
        .OUT_READY     (w_out_ready),
        .OUT_RESULT    (w_out_result),
        .OUT_RESULT_HI (w_out_result_hi),
        .OUT_FLAGS     (w_out_flags)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one op, accept it, scramble the inputs, then count cycles to OUT_VALID
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            total_cnt++;
            $display("FAIL issue_ready_timeout: IN_READY got %b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        op_code  = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = b ^ 8'h5A;
        op_code  = op ^ 4'h3;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Take the pending result with a single-cycle OUT_READY pulse
    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RESET     = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'hFF;
        in_b      = 8'h01;
        op_code   = 4'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({out_result, out_result_hi, out_flags} !== 20'h0)
            $display("FAIL reset_outputs: got %h required 00000", {out_result, out_result_hi, out_flags});
        else pass_cnt++;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        RESET     = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL idle_no_valid: got %b required 0", out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_cycle_ops();
        logic [31:0] v;
        int lat;
        for (int i = 0; i < 17; i++) begin
            v = VECS[i];
            issue(v[27:20], v[19:12], v[31:28], lat);
            total_cnt++;
            if (lat !== 1) $display("FAIL op%0h_latency: got %0d required 1", v[31:28], lat);
            else pass_cnt++;
            total_cnt++;
            if (out_result !== v[11:4])
                $display("FAIL op%0h_result: got %h required %h", v[31:28], out_result, v[11:4]);
            else pass_cnt++;
            total_cnt++;
            if (out_flags !== v[3:0])
                $display("FAIL op%0h_flags: got %b required %b", v[31:28], out_flags, v[3:0]);
            else pass_cnt++;
            total_cnt++;
            if (out_result_hi !== 8'h00)
                $display("FAIL op%0h_hi: got %h required 00", v[31:28], out_result_hi);
            else pass_cnt++;
            consume();
        end
    endtask

    task automatic test_multiply();
        logic [7:0] ma [0:2];
        logic [7:0] mb [0:2];
        logic [7:0] mlo [0:2];
        logic [7:0] mhi [0:2];
        logic [3:0] mf [0:2];
        int lat;
        ma[0] = 8'h10; mb[0] = 8'h20; mlo[0] = 8'h00; mhi[0] = 8'h02; mf[0] = 4'b0011;
        ma[1] = 8'hFF; mb[1] = 8'hFF; mlo[1] = 8'h01; mhi[1] = 8'hFE; mf[1] = 4'b0010;
        ma[2] = 8'h03; mb[2] = 8'h05; mlo[2] = 8'h0F; mhi[2] = 8'h00; mf[2] = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            issue(ma[i], mb[i], 4'h2, lat);
            total_cnt++;
            if (lat !== 9) $display("FAIL mul%0d_latency: got %0d required 9", i, lat);
            else pass_cnt++;
            total_cnt++;
            if ({out_result_hi, out_result} !== {mhi[i], mlo[i]})
                $display("FAIL mul%0d_product: got %h required %h", i,
                         {out_result_hi, out_result}, {mhi[i], mlo[i]});
            else pass_cnt++;
            total_cnt++;
            if (out_flags !== mf[i])
                $display("FAIL mul%0d_flags: got %b required %b", i, out_flags, mf[i]);
            else pass_cnt++;
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(8'h12, 8'h34, 4'h0, lat);
        in_valid = 1'b1;
        in_a     = 8'h0F;
        in_b     = 8'hF0;
        op_code  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 8'h46 || out_flags !== 4'b0000)
                $display("FAIL hold_cycle%0d: got ready=%b valid=%b res=%h flags=%b required ready=0 valid=1 res=46 flags=0000",
                         i, in_ready, out_valid, out_result, out_flags);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL handoff_idle: got ready=%b valid=%b required ready=1 valid=0", in_ready, out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_result !== 8'hFF || out_flags !== 4'b0100)
            $display("FAIL pending_op: got valid=%b res=%h flags=%b required valid=1 res=ff flags=0100",
                     out_valid, out_result, out_flags);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        bit stale;
        in_valid = 1'b1;
        in_a     = 8'h10;
        in_b     = 8'h20;
        op_code  = 4'h2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL mul_busy_ready: got %b required 0", in_ready);
        else pass_cnt++;
        RESET = 1'b1;
        @(posedge clk); #1;
        RESET = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || {out_result, out_result_hi, out_flags} !== 20'h0)
            $display("FAIL mul_reset_outputs: got valid=%b %h required valid=0 00000",
                     out_valid, {out_result, out_result_hi, out_flags});
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL mul_reset_ready: got %b required 1", in_ready);
        else pass_cnt++;
        stale = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        total_cnt++;
        if (stale) $display("FAIL mul_reset_stale: got valid=1 required 0");
        else pass_cnt++;
        issue(8'h01, 8'h02, 4'h0, lat);
        total_cnt++;
        if (lat !== 1 || out_result !== 8'h03)
            $display("FAIL post_reset_add: got lat=%0d res=%h required lat=1 res=03", lat, out_result);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_wide_shl();
        w_in_valid = 1'b1;
        w_in_a     = 16'h8001;
        w_in_b     = 16'h0000;
        w_op_code  = 4'h3;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        w_in_a     = 16'h0000;
        total_cnt++;
        if (w_out_valid !== 1'b1 || w_out_result !== 16'h0002 || w_out_result_hi !== 16'h0000)
            $display("FAIL w16_shl_result: got valid=%b res=%h hi=%h required valid=1 res=0002 hi=0000",
                     w_out_valid, w_out_result, w_out_result_hi);
        else pass_cnt++;
        total_cnt++;
        if (w_out_flags !== 4'b0010)
            $display("FAIL w16_shl_flags: got %b required 0010", w_out_flags);
        else pass_cnt++;
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
    endtask

    // Sequence all scenarios and print the summary
    initial begin
        RESET       = 1'b1;
        in_valid    = 1'b0;
        in_a        = 8'h00;
        in_b        = 8'h00;
        op_code     = 4'h0;
        out_ready   = 1'b0;
        w_in_valid  = 1'b0;
        w_in_a      = 16'h0000;
        w_in_b      = 16'h0000;
        w_op_code   = 4'h0;
        w_out_ready = 1'b0;
        test_reset();
        test_single_cycle_ops();
        test_multiply();
        test_backpressure();
        test_reset_mid_mul();
        test_wide_shl();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
